cla4_adder: RTL and testbench

CLA4_ADDER -- requirements
Module: cla4_adder

---
 rtl/cla_pkg.sv | 13 +
 rtl/cla4_core.sv | 37 +++
 rtl/cla4_adder.sv | 54 +++++
 tb/tb_cla4_adder.sv | 139 +++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared width constant and result record for the 4-bit carry-lookahead adder.
package cla_pkg;

  localparam int unsigned CLA_W = 4;

  typedef struct packed {
    logic             cout;
    logic [CLA_W-1:0] y;
    logic             pg;
    logic             gg;
  } cla_res_t;

endpackage

// File: rtl/cla4_core.sv
// Combinational 4-bit carry-lookahead: two-level carries plus group propagate/generate.
module cla4_core
  import cla_pkg::*;
(
  input  logic [CLA_W-1:0] a,
  input  logic [CLA_W-1:0] b,
  input  logic             cin,
  output logic [CLA_W-1:0] y,
  output logic             cout,
  output logic             pg,
  output logic             gg
);

  logic [CLA_W-1:0] g;
  logic [CLA_W-1:0] p;
  logic [CLA_W:0]   c;

  always_comb begin
    g = a & b;
    p = a ^ b;

    // Every carry is a flat sum-of-products of g/p/cin; no carry feeds another.
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);

    y    = p ^ c[CLA_W-1:0];
    cout = c[4];
    pg   = &p;
    gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  end

endmodule

// File: rtl/cla4_adder.sv
// Registered 4-bit CLA adder: one-cycle latency, results hold while in_valid is low.
module cla4_adder
  import cla_pkg::*;
(
  input  logic [CLA_W-1:0] a,
  input  logic [CLA_W-1:0] b,
  input  logic             cin,
  output logic             cout,
  output logic [CLA_W-1:0] y,
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             out_valid,
  output logic             pg,
  output logic             gg
);

  cla_res_t core_res;
  cla_res_t res_d;
  cla_res_t res_q;
  logic     valid_q;

  cla4_core u_core (
    .a    (a),
    .b    (b),
    .cin  (cin),
    .y    (core_res.y),
    .cout (core_res.cout),
    .pg   (core_res.pg),
    .gg   (core_res.gg)
  );

  always_comb begin
    res_d = res_q;
    if (in_valid) res_d = core_res;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      res_q   <= res_d;
      valid_q <= in_valid;
    end
  end

  assign cout      = res_q.cout;
  assign y         = res_q.y;
  assign pg        = res_q.pg;
  assign gg        = res_q.gg;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_cla4_adder.sv
// Randomised and directed bench for cla4_adder against an arithmetic reference model.
module tb_cla4_adder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] a = '0;
  logic [3:0] b = '0;
  logic       cin = 1'b0;
  logic       in_valid = 1'b0;
  logic       cout;
  logic [3:0] y;
  logic       out_valid;
  logic       pg;
  logic       gg;

  int n_cmp = 0;
  int n_bad = 0;

  cla4_adder dut (
    .a         (a),
    .b         (b),
    .cin       (cin),
    .cout      (cout),
    .y         (y),
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .out_valid (out_valid),
    .pg        (pg),
    .gg        (gg)
  );

  always #5 clk = ~clk;

  // Reference: plain integer addition; pg means a+b is exactly 15, gg means a+b overflows alone.
  int   ab_sum;
  int   abc_sum;
  logic exp_v = 1'b0;
  logic exp_cout = 1'b0;
  logic [3:0] exp_y = '0;
  logic exp_pg = 1'b0;
  logic exp_gg = 1'b0;
  logic model_live = 1'b0;

  assign ab_sum  = int'(a) + int'(b);
  assign abc_sum = ab_sum + int'(cin);

  always @(posedge clk) begin
    if (rst) begin
      exp_v      <= 1'b0;
      exp_cout   <= 1'b0;
      exp_y      <= '0;
      exp_pg     <= 1'b0;
      exp_gg     <= 1'b0;
      model_live <= 1'b1;
    end else begin
      exp_v <= in_valid;
      if (in_valid) begin
        exp_cout <= (abc_sum >= 16);
        exp_y    <= 4'(abc_sum % 16);
        exp_pg   <= (ab_sum == 15);
        exp_gg   <= (ab_sum >= 16);
      end
    end
  end

  always @(negedge clk) begin
    if (model_live) begin
      n_cmp++;
      if ({out_valid, cout, y, pg, gg} !== {exp_v, exp_cout, exp_y, exp_pg, exp_gg}) begin
        n_bad++;
        $display("FAIL model t=%0t got v=%b c=%b y=%0d pg=%b gg=%b want v=%b c=%b y=%0d pg=%b gg=%b",
                 $time, out_valid, cout, y, pg, gg, exp_v, exp_cout, exp_y, exp_pg, exp_gg);
      end
    end
  end

  // Drive at negedge so the next posedge samples stable inputs; returns at the following negedge.
  task automatic step(input logic r, input logic v, input logic [3:0] ai,
                      input logic [3:0] bi, input logic ci);
    rst = r; in_valid = v; a = ai; b = bi; cin = ci;
    @(negedge clk);
  endtask

  task automatic lit(input string name, input logic ev, input logic ec,
                     input logic [3:0] ey, input logic ep, input logic eg);
    n_cmp++;
    if ({out_valid, cout, y, pg, gg} !== {ev, ec, ey, ep, eg}) begin
      n_bad++;
      $display("FAIL %s got v=%b c=%b y=%0d pg=%b gg=%b want v=%b c=%b y=%0d pg=%b gg=%b",
               name, out_valid, cout, y, pg, gg, ev, ec, ey, ep, eg);
    end
  endtask

  initial begin
    @(negedge clk);
    step(1'b1, 1'b1, 4'd5, 4'd9, 1'b1);
    lit("reset", 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);

    step(1'b0, 1'b1, 4'd0, 4'd0, 1'b0);
    lit("zero", 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 4'd3, 4'd2, 1'b1);
    lit("3+2+1", 1'b1, 1'b0, 4'd6, 1'b0, 1'b0);
    step(1'b0, 1'b1, 4'd7, 4'd10, 1'b0);
    lit("7+10", 1'b1, 1'b1, 4'd1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 4'd15, 4'd15, 1'b1);
    lit("15+15+1", 1'b1, 1'b1, 4'd15, 1'b0, 1'b1);
    step(1'b0, 1'b1, 4'd15, 4'd0, 1'b1);
    lit("15+0+1", 1'b1, 1'b1, 4'd0, 1'b1, 1'b0);

    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 4'($urandom_range(15)), 4'($urandom_range(15)), 1'($urandom_range(1)));
      lit("hold", 1'b0, 1'b1, 4'd0, 1'b1, 1'b0);
    end

    step(1'b0, 1'b1, 4'd9, 4'd4, 1'b0);
    step(1'b1, 1'b1, 4'd7, 4'd10, 1'b0);
    lit("midrst", 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 4'd3, 4'd2, 1'b1);
    lit("resume", 1'b1, 1'b0, 4'd6, 1'b0, 1'b0);

    for (int i = 0; i < 512; i++) begin
      logic [8:0] v9;
      v9 = 9'(i);
      step(1'b0, 1'b1, v9[8:5], v9[4:1], v9[0]);
    end

    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(39) == 0), ($urandom_range(3) != 0),
           4'($urandom_range(15)), 4'($urandom_range(15)), 1'($urandom_range(1)));
    end

    step(1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
    step(1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
